auto_shift_controller: RTL and testbench

Closed-loop controller that picks the `shift` value driven into the arithmetic right-shifter of the acquisition datapath. It tracks the peak magnitude of the incoming signed samples over a window of 2^WINDOW_LOG2 valid samples and converts the headroom of that peak into a requested shift. It slews its `shift` output one step per window toward that request. A manual mode bypasses the loop so software can force a fixed shift.

---
 rtl/auto_shift_controller_if.sv | 27 ++
 rtl/auto_shift_controller.sv | 110 +++++++++++
 tb/tb_auto_shift_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/auto_shift_controller_if.sv
// Sample-stream and control bundle between the acquisition datapath and the
// automatic shift controller.
interface auto_shift_controller_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int TOTAL_WIDTH = 48
);
  localparam int SW = $clog2(TOTAL_WIDTH) + 1;

  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         auto_en;
  logic [SW-1:0]                shift_manual;
  logic [SW-1:0]                shift;
  logic [DATA_WIDTH-2:0]        peak;
  logic                         window_done;
  logic                         shift_changed;

  modport master (
    output in_data, in_valid, auto_en, shift_manual,
    input  shift, peak, window_done, shift_changed
  );

  modport slave (
    input  in_data, in_valid, auto_en, shift_manual,
    output shift, peak, window_done, shift_changed
  );
endinterface

// File: rtl/auto_shift_controller.sv
// Closed-loop shift controller: measures the peak magnitude of each window of
// valid samples and slews the shifter's shift one step per window toward the headroom target.
module auto_shift_controller #(
  parameter int DATA_WIDTH  = 16,
  parameter int TOTAL_WIDTH = 48,
  parameter int WINDOW_LOG2 = 10,
  parameter int BASE_SHIFT  = 16,
  parameter int MIN_SHIFT   = 0
) (
  input logic                   clk,
  input logic                   resetn,
  auto_shift_controller_if.slave bus
);
  localparam int SW = $clog2(TOTAL_WIDTH) + 1;
  localparam int MW = DATA_WIDTH - 1;

  typedef enum logic [1:0] {MANUAL, ACCUM, UPDATE} state_t;

  state_t                 state_reg;
  logic [WINDOW_LOG2-1:0] cnt_reg;
  logic [MW-1:0]          run_max_reg;
  logic [MW-1:0]          peak_reg;
  logic [SW-1:0]          shift_reg;
  logic                   window_done_reg;
  logic                   shift_changed_reg;

  logic [MW-1:0]          mag;
  logic [MW-1:0]          win_max;
  logic [SW-1:0]          manual_clamped;
  logic [SW-1:0]          shift_next;
  int                     msb_idx;
  int                     req;

  // One's-complement magnitude: XOR with the sign bit, no adder on the sample path.
  genvar gi;
  generate
    for (gi = 0; gi < MW; gi++) begin : g_mag
      assign mag[gi] = bus.in_data[DATA_WIDTH-1] ^ bus.in_data[gi];
    end
  endgenerate

  assign win_max        = (mag > run_max_reg) ? mag : run_max_reg;
  assign manual_clamped = (bus.shift_manual > SW'(TOTAL_WIDTH)) ? SW'(TOTAL_WIDTH) : bus.shift_manual;

  // msb_idx = -1 for a zero peak makes headroom come out as DATA_WIDTH-1 uniformly.
  always_comb begin
    msb_idx = -1;
    for (int i = 0; i < MW; i++) begin
      if (peak_reg[i]) msb_idx = i;
    end
    req = BASE_SHIFT - (DATA_WIDTH - 2 - msb_idx);
    if (req < MIN_SHIFT) req = MIN_SHIFT;
    shift_next = shift_reg;
    if (req > int'(shift_reg)) shift_next = shift_reg + SW'(1);
    else if (req < int'(shift_reg)) shift_next = shift_reg - SW'(1);
  end

  always_ff @(posedge clk) begin
    window_done_reg   <= 1'b0;
    shift_changed_reg <= 1'b0;
    if (!resetn) begin
      state_reg   <= bus.auto_en ? ACCUM : MANUAL;
      cnt_reg     <= '0;
      run_max_reg <= '0;
      peak_reg    <= '0;
      shift_reg   <= SW'(BASE_SHIFT);
    end else if (!bus.auto_en) begin
      state_reg   <= MANUAL;
      cnt_reg     <= '0;
      run_max_reg <= '0;
      shift_reg   <= manual_clamped;
    end else begin
      case (state_reg)
        MANUAL: begin
          state_reg   <= ACCUM;
          cnt_reg     <= '0;
          run_max_reg <= '0;
        end
        ACCUM: begin
          if (bus.in_valid) begin
            if (&cnt_reg) begin
              peak_reg        <= win_max;
              window_done_reg <= 1'b1;
              state_reg       <= UPDATE;
              cnt_reg         <= '0;
              run_max_reg     <= '0;
            end else begin
              cnt_reg     <= cnt_reg + WINDOW_LOG2'(1);
              run_max_reg <= win_max;
            end
          end
        end
        UPDATE: begin
          shift_reg         <= shift_next;
          shift_changed_reg <= (shift_next != shift_reg);
          // Sampling never pauses: a sample here opens the next window.
          cnt_reg           <= bus.in_valid ? WINDOW_LOG2'(1) : '0;
          run_max_reg       <= bus.in_valid ? mag : '0;
          state_reg         <= ACCUM;
        end
        default: state_reg <= MANUAL;
      endcase
    end
  end

  assign bus.shift         = shift_reg;
  assign bus.peak          = peak_reg;
  assign bus.window_done   = window_done_reg;
  assign bus.shift_changed = shift_changed_reg;
endmodule

// File: tb/tb_auto_shift_controller.sv
// Randomized bench: two controllers (MIN_SHIFT 0 and 4) share one stimulus
// stream and are compared every cycle against a window-level reference model.
module tb_auto_shift_controller;
  localparam int DW   = 16;
  localparam int TW   = 48;
  localparam int BASE = 16;
  localparam int WIN  = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              auto_en;
  logic              in_valid;
  logic signed [15:0] in_data;
  logic [6:0]        shift_manual;

  int n_checks = 0;
  int n_fail   = 0;
  int n_win    = 0;

  int m_shift [2];
  int m_peak  [2];
  int m_wd    [2];
  int m_sc    [2];
  int m_n     [2];
  bit m_pend  [2];
  bit m_manual[2];
  int m_buf   [2][WIN];

  always #5 clk = ~clk;

  auto_shift_controller_if #(.DATA_WIDTH(DW), .TOTAL_WIDTH(TW)) bus0 ();
  auto_shift_controller_if #(.DATA_WIDTH(DW), .TOTAL_WIDTH(TW)) bus1 ();

  assign bus0.in_data = in_data;  assign bus0.in_valid = in_valid;
  assign bus0.auto_en = auto_en;  assign bus0.shift_manual = shift_manual;
  assign bus1.in_data = in_data;  assign bus1.in_valid = in_valid;
  assign bus1.auto_en = auto_en;  assign bus1.shift_manual = shift_manual;

  auto_shift_controller #(
    .DATA_WIDTH(DW), .TOTAL_WIDTH(TW), .WINDOW_LOG2(2), .BASE_SHIFT(BASE), .MIN_SHIFT(0)
  ) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));

  auto_shift_controller #(
    .DATA_WIDTH(DW), .TOTAL_WIDTH(TW), .WINDOW_LOG2(2), .BASE_SHIFT(BASE), .MIN_SHIFT(4)
  ) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int min_of(input int k);
    return (k == 0) ? 0 : 4;
  endfunction

  // Magnitude as the spec defines it arithmetically: -x-1 for negatives.
  function automatic int mag_of(input int x);
    return (x < 0) ? -x - 1 : x;
  endfunction

  function automatic int bitlen(input int v);
    int b = 0;
    while ((1 << b) <= v) b++;
    return b;
  endfunction

  task automatic model_step(input int k);
    int req;
    int pk;
    m_wd[k] = 0;
    m_sc[k] = 0;
    if (!resetn) begin
      m_shift[k] = BASE; m_peak[k] = 0; m_n[k] = 0; m_pend[k] = 0;
      m_manual[k] = !auto_en;
    end else if (!auto_en) begin
      m_shift[k] = (int'(shift_manual) > TW) ? TW : int'(shift_manual);
      m_n[k] = 0; m_pend[k] = 0; m_manual[k] = 1;
    end else if (m_manual[k]) begin
      m_manual[k] = 0; m_n[k] = 0;
    end else begin
      if (m_pend[k]) begin
        req = BASE - (DW - 1 - bitlen(m_peak[k]));
        if (req < min_of(k)) req = min_of(k);
        if (req != m_shift[k]) begin
          m_shift[k] += (req > m_shift[k]) ? 1 : -1;
          m_sc[k] = 1;
        end
        m_pend[k] = 0;
      end
      if (in_valid) begin
        m_buf[k][m_n[k]] = mag_of(int'(in_data));
        m_n[k]++;
        if (m_n[k] == WIN) begin
          pk = 0;
          for (int j = 0; j < WIN; j++) if (m_buf[k][j] > pk) pk = m_buf[k][j];
          m_peak[k] = pk; m_wd[k] = 1; m_pend[k] = 1; m_n[k] = 0;
          if (k == 0) begin
            n_win++;
            $display("window %0d: peak=0x%04h shift=%0d", n_win, pk, m_shift[0]);
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("shift0",   32'(bus0.shift),         m_shift[0]);
    check("peak0",    32'(bus0.peak),          m_peak[0]);
    check("wdone0",   32'(bus0.window_done),   m_wd[0]);
    check("schg0",    32'(bus0.shift_changed), m_sc[0]);
    check("shift1",   32'(bus1.shift),         m_shift[1]);
    check("peak1",    32'(bus1.peak),          m_peak[1]);
    check("wdone1",   32'(bus1.window_done),   m_wd[1]);
    check("schg1",    32'(bus1.shift_changed), m_sc[1]);
  endtask

  task automatic tick(input bit v, input logic [15:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic window4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    tick(1'b1, a); tick(1'b1, b); tick(1'b1, c); tick(1'b1, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pos;
    int manual_left;
    bit prev_auto;
    logic [15:0] d;
    logic signed [15:0] s;

    resetn = 1'b0; auto_en = 1'b1; shift_manual = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) tick(1'b0, 16'h0000);
    resetn = 1'b1;
    tick(1'b0, 16'h0000);

    // Full-scale windows: shift holds at BASE.
    repeat (2) window4(16'h7FFF, 16'h8000, 16'h0000, 16'h0005);
    tick(1'b0, 16'h0000);

    // Peak magnitude 0x0100 -> shift walks down to 10.
    repeat (8) begin
      pos = $urandom_range(0, 3);
      for (int j = 0; j < 4; j++) begin
        if (j == pos) d = $urandom_range(0, 1) ? 16'h0100 : 16'hFEFF;
        else d = 16'($urandom_range(0, 511)) - 16'd256;
        tick(1'b1, d);
      end
    end

    // Zero-magnitude windows (0 and -1) -> shift to 1 / clamp at 4.
    repeat (12) begin
      for (int j = 0; j < 4; j++) tick(1'b1, $urandom_range(0, 1) ? 16'hFFFF : 16'h0000);
    end

    // Windows of only -32768 -> full-scale peak, shift climbs one per window.
    repeat (5) window4(16'h8000, 16'h8000, 16'h8000, 16'h8000);

    // Sparse valid: one sample every 3rd cycle.
    for (int i = 0; i < 24; i++) tick((i % 3) == 2, 16'($urandom));

    // Manual mode, including values above TOTAL_WIDTH.
    auto_en = 1'b0;
    shift_manual = 7'd60;  tick(1'b0, 16'h0000); tick(1'b1, 16'h1234);
    shift_manual = 7'd20;  tick(1'b0, 16'h0000); tick(1'b0, 16'h0000);
    shift_manual = 7'd127; tick(1'b0, 16'h0000);
    shift_manual = 7'd48;  tick(1'b0, 16'h0000);
    shift_manual = 7'd49;  tick(1'b0, 16'h0000);
    shift_manual = 7'd3;   tick(1'b0, 16'h0000);

    // Partial window discarded on auto_en drop.
    auto_en = 1'b1; tick(1'b0, 16'h0000);
    tick(1'b1, 16'h7000); tick(1'b1, 16'h0010); tick(1'b1, 16'h0020);
    auto_en = 1'b0; tick(1'b1, 16'h0030); tick(1'b0, 16'h0000);
    auto_en = 1'b1; tick(1'b0, 16'h0000);
    window4(16'h0040, 16'hFF00, 16'h0002, 16'h0001);
    repeat (3) tick(1'b0, 16'h0000);

    // Random traffic with occasional manual excursions.
    manual_left = 0;
    prev_auto = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (manual_left == 0 && $urandom_range(0, 99) == 0) manual_left = $urandom_range(1, 5);
      if (manual_left > 0) begin
        auto_en = 1'b0;
        manual_left--;
      end else begin
        auto_en = 1'b1;
      end
      shift_manual = 7'($urandom_range(0, 127));
      s = 16'($urandom);
      s = s >>> $urandom_range(0, 15);
      tick((auto_en && !prev_auto) ? 1'b0 : 1'($urandom_range(0, 1)), s);
      prev_auto = auto_en;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
